// File: rtl/counting.sv
// Recognises 1^a 2^b 3^c (a,b,c >= 1) on a 2-bit symbol stream; optional hit counter under COUNTING_HIT_CNT_EN.
// Latency: ans rises the cycle after the edge that samples the first qualifying 3 (Moore, registered).
// Backpressure: none; one symbol is consumed every clock, the producer is never stalled.
module counting #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       num,
`ifdef COUNTING_HIT_CNT_EN
    output logic [CNT_W-1:0] hit_cnt,
`endif
    output logic             ans
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Reject counter widths the saturating logic was not sized for.
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("counting: CNT_W must be in 1..32");
    end

    // Next-state: a 1 always (re)starts the pattern, 0 always clears it,
    // 2 and 3 only extend a run that is already in the right phase.
    always_comb begin
        state_nxt = state;
        case (num)
            2'd0: state_nxt = IDLE;
            2'd1: state_nxt = S1;
            2'd2: state_nxt = (state == S1 || state == S2) ? S2 : IDLE;
            2'd3: state_nxt = (state == S2 || state == S3) ? S3 : IDLE;
        endcase
    end

    // State register and registered match flag; reset wins over num.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ans   <= 1'b0;
        end else begin
            state <= state_nxt;
            ans   <= (state_nxt == S3);
        end
    end

`ifdef COUNTING_HIT_CNT_EN
    // Count entries into S3 from S2 only, so trailing 3s are not recounted; saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt <= '0;
        end else if (state == S2 && state_nxt == S3 && hit_cnt != {CNT_W{1'b1}}) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_counting.sv
// Directed bench for the counting recogniser: expected ans values are queued as each symbol is driven.
// Latency: checks sample one time unit after the edge that consumed the symbol.
// Backpressure: none; one symbol per clock.
module tb_counting;

    localparam int CNT_W = 2;

    logic             clk;
    logic             reset;
    logic [1:0]       num;
    logic             ans;
`ifdef COUNTING_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt;
`endif

    int   total;
    int   passes;
    logic exp_q[$];

    counting #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .num     (num),
`ifdef COUNTING_HIT_CNT_EN
        .hit_cnt (hit_cnt),
`endif
        .ans     (ans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one symbol (with reset level), queue its expected ans, then pop and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic [1:0] n, input logic e);
        logic exp_v;
        logic got;
        reset = rst;
        num   = n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got   = ans;
        total = total + 1;
        if (exp_q.size() == 0) begin
            $error("FAIL %s scoreboard empty got=%b", tag, got);
        end else begin
            exp_v = exp_q.pop_front();
            assert (got === exp_v) passes = passes + 1;
            else $error("FAIL %s ans got=%b exp=%b", tag, got, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag, input int e);
`ifdef COUNTING_HIT_CNT_EN
        total = total + 1;
        assert (hit_cnt === CNT_W'(e)) passes = passes + 1;
        else $error("FAIL %s hit_cnt got=%0d exp=%0d", tag, hit_cnt, e);
`else
        if (tag.len() < 0 || e < 0) $display("unused");
`endif
    endtask

    initial begin
        total  = 0;
        passes = 0;
        reset  = 1'b1;
        num    = 2'd0;

        // Reset state
        step("rst0", 1'b1, 2'd0, 1'b0);
        step("rst1", 1'b1, 2'd3, 1'b0);
        chk_cnt("rst_cnt", 0);

        // Basic 1,2,3,3,0 right after reset release
        step("t1_1", 1'b0, 2'd1, 1'b0);
        step("t1_2", 1'b0, 2'd2, 1'b0);
        step("t1_3", 1'b0, 2'd3, 1'b1);
        step("t1_3b", 1'b0, 2'd3, 1'b1);
        chk_cnt("t1_cnt_hold", 1);
        step("t1_0", 1'b0, 2'd0, 1'b0);
        chk_cnt("t1_cnt", 1);

        // Longer runs: 1,1,2,2,2,3
        step("t2_rst", 1'b1, 2'd0, 1'b0);
        step("t2_a", 1'b0, 2'd1, 1'b0);
        step("t2_b", 1'b0, 2'd1, 1'b0);
        step("t2_c", 1'b0, 2'd2, 1'b0);
        step("t2_d", 1'b0, 2'd2, 1'b0);
        step("t2_e", 1'b0, 2'd2, 1'b0);
        step("t2_f", 1'b0, 2'd3, 1'b1);

        // Broken patterns: 1,3 / 2,3 / 1,2,0,3 / 3
        step("t3_clr", 1'b0, 2'd0, 1'b0);
        step("t3_13a", 1'b0, 2'd1, 1'b0);
        step("t3_13b", 1'b0, 2'd3, 1'b0);
        step("t3_23a", 1'b0, 2'd2, 1'b0);
        step("t3_23b", 1'b0, 2'd3, 1'b0);
        step("t3_1203a", 1'b0, 2'd1, 1'b0);
        step("t3_1203b", 1'b0, 2'd2, 1'b0);
        step("t3_1203c", 1'b0, 2'd0, 1'b0);
        step("t3_1203d", 1'b0, 2'd3, 1'b0);
        step("t3_3", 1'b0, 2'd3, 1'b0);

        // Restart: 1,2,3,1,2,3 then 1,2,3,2
        step("t4_rst", 1'b1, 2'd0, 1'b0);
        chk_cnt("t4_cnt0", 0);
        step("t4_a", 1'b0, 2'd1, 1'b0);
        step("t4_b", 1'b0, 2'd2, 1'b0);
        step("t4_c", 1'b0, 2'd3, 1'b1);
        step("t4_d", 1'b0, 2'd1, 1'b0);
        step("t4_e", 1'b0, 2'd2, 1'b0);
        step("t4_f", 1'b0, 2'd3, 1'b1);
        chk_cnt("t4_cnt", 2);
        step("t4_rst2", 1'b1, 2'd0, 1'b0);
        step("t4_g", 1'b0, 2'd1, 1'b0);
        step("t4_h", 1'b0, 2'd2, 1'b0);
        step("t4_i", 1'b0, 2'd3, 1'b1);
        step("t4_j", 1'b0, 2'd2, 1'b0);

        // Reset mid-match discards history
        step("t5_rst", 1'b1, 2'd0, 1'b0);
        step("t5_a", 1'b0, 2'd1, 1'b0);
        step("t5_b", 1'b0, 2'd2, 1'b0);
        step("t5_c", 1'b0, 2'd3, 1'b1);
        step("t5_r", 1'b1, 2'd3, 1'b0);
        chk_cnt("t5_cnt_r", 0);
        step("t5_d", 1'b0, 2'd3, 1'b0);
        chk_cnt("t5_cnt", 0);

        // Saturation: five full patterns with a 2-bit counter
        step("t6_rst", 1'b1, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step("t6_1", 1'b0, 2'd1, 1'b0);
            step("t6_2", 1'b0, 2'd2, 1'b0);
            step("t6_3", 1'b0, 2'd3, 1'b1);
            chk_cnt("t6_cnt", (k + 1 > 3) ? 3 : k + 1);
        end
        step("t6_3x", 1'b0, 2'd3, 1'b1);
        chk_cnt("t6_hold", 3);

        total = total + 1;
        assert (exp_q.size() == 0) passes = passes + 1;
        else $error("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
